// File: rtl/sender_arbiter.sv
// sender_arbiter: round-robin arbiter that sequences byte requesters onto one serial sender.
// Optional Acks timeout in WAIT_HI is built when SENDER_ARB_TIMEOUT_EN is defined.
module sender_arbiter #(
  parameter int N_REQ       = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                     clks,
  input  logic                     resets_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*8-1:0]       req_data,
  output logic [N_REQ-1:0]         grant,
  output logic                     send,
  output logic [7:0]               char_to_send,
  input  logic                     Acks,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     timeout_err
);
  localparam int OW = $clog2(N_REQ);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO, GAP} state_t;

  state_t            r_state, w_next;
  logic [OW-1:0]     r_owner, w_win, w_idx;
  logic [N_REQ-1:0]  r_grant;
  logic [7:0]        r_char;
  logic [GW-1:0]     r_gap;
  logic              r_send, w_issue, w_to;

  assign w_issue      = r_state == IDLE && |req && !Acks;
  assign grant        = r_grant;
  assign send         = r_send;
  assign char_to_send = r_char;
  assign owner        = r_owner;
  assign busy         = r_state != IDLE;

  // descending scan so the nearest requester after owner is the last assignment
  always_comb begin
    w_win = r_owner;
    w_idx = r_owner;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = OW'((int'(r_owner) + k) % N_REQ);
      if (req[w_idx]) w_win = w_idx;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_issue ? WAIT_HI : IDLE;
      WAIT_HI: w_next = Acks ? WAIT_LO : w_to ? IDLE : WAIT_HI;
      WAIT_LO: w_next = Acks ? WAIT_LO : GAP_CYCLES == 0 ? IDLE : GAP;
      GAP:     w_next = r_gap == '0 ? IDLE : GAP;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clks or negedge resets_n) begin
    if (!resets_n) begin
      r_state <= IDLE;
      r_send  <= 1'b0;
      r_grant <= '0;
      r_char  <= 8'h00;
      r_owner <= OW'(N_REQ - 1);
      r_gap   <= '0;
    end else begin
      r_state <= w_next;
      r_send  <= w_issue;
      r_grant <= w_issue ? N_REQ'(1) << w_win : '0;
      if (w_issue) begin
        r_char  <= req_data[8*w_win +: 8];
        r_owner <= w_win;
      end
      if (r_state == WAIT_LO) r_gap <= GW'(GAP_CYCLES - 1);
      else if (r_state == GAP) r_gap <= r_gap - 1'b1;
    end
  end

`ifdef SENDER_ARB_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] r_to;
  logic          r_err;
  assign w_to        = r_state == WAIT_HI && !Acks && r_to == TW'(ACK_TIMEOUT);
  assign timeout_err = r_err;
  always_ff @(posedge clks or negedge resets_n) begin
    if (!resets_n) begin
      r_to  <= '0;
      r_err <= 1'b0;
    end else begin
      r_to <= w_issue ? '0 : r_state == WAIT_HI ? r_to + 1'b1 : r_to;
      if (w_to) r_err <= 1'b1;
    end
  end
`else
  assign w_to        = 1'b0;
  assign timeout_err = 1'b0;
`endif
endmodule
